decoder_scan_ctrl: RTL and testbench



---
 rtl/scan_pkg.sv | 14 +
 rtl/dwell_timer.sv | 29 ++
 rtl/decoder_scan_ctrl.sv | 119 +++++++++++
 tb/tb_decoder_scan_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared encodings and widths for the decoder scan controller.
// GAP is only reachable when SCAN_BLANK_GAP_EN is defined.
package scan_pkg;

    localparam int ADDR_W  = 4;
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts held cycles at one address and flags the last one.
// Clear wins over count enable.
module dwell_timer
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic count_en,
    output logic tc
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == DWELL_W'(PRESCALE - 1));

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Walks the 4-to-16 decoder select 0..LAST_ADDR, holding each address PRESCALE cycles.
// Optional SCAN_BLANK_GAP_EN inserts a one-cycle En=0 gap at every address change.
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int PRESCALE  = 4,
    parameter int LAST_ADDR = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Mode,
    input  logic              Hold,
    output logic [ADDR_W-1:0] w,
    output logic              En,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        scan_state
);

    localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(LAST_ADDR);

    initial begin
        if (PRESCALE < 1 || PRESCALE > 255)
            $fatal(1, "decoder_scan_ctrl: PRESCALE must be 1..255");
        if (LAST_ADDR < 0 || LAST_ADDR > 15)
            $fatal(1, "decoder_scan_ctrl: LAST_ADDR must be 0..15");
    end

    scan_state_e state;
    logic        mode_q;
    logic        tc;
    logic        advance;
    logic        dwell_clear;
    logic        dwell_en;

    // The counter only runs in SCAN; every other state parks it at zero.
    assign advance     = (state == ST_SCAN) && !Stop && !Hold;
    assign dwell_clear = (state != ST_SCAN) || Stop || (advance && tc);
    assign dwell_en    = advance && !tc;
    assign scan_state  = state;

    dwell_timer #(.PRESCALE(PRESCALE)) u_dwell (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (dwell_clear),
        .count_en(dwell_en),
        .tc      (tc)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            w      <= '0;
            En     <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Stop) begin
                state <= ST_IDLE;
                w     <= '0;
                En    <= 1'b0;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (Start) begin
                            state  <= ST_SCAN;
                            w      <= '0;
                            En     <= 1'b1;
                            Busy   <= 1'b1;
                            mode_q <= Mode;
                        end
                    end
                    ST_SCAN: begin
                        if (!Hold && tc) begin
                            if (w < LAST_W) begin
                                w <= w + 1'b1;
`ifdef SCAN_BLANK_GAP_EN
                                state <= ST_GAP;
                                En    <= 1'b0;
`endif
                            end else if (mode_q) begin
                                w    <= '0;
                                Done <= 1'b1;
`ifdef SCAN_BLANK_GAP_EN
                                state <= ST_GAP;
                                En    <= 1'b0;
`endif
                            end else begin
                                state <= ST_IDLE;
                                w     <= '0;
                                En    <= 1'b0;
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                            end
                        end
                    end
`ifdef SCAN_BLANK_GAP_EN
                    ST_GAP: begin
                        state <= ST_SCAN;
                        En    <= 1'b1;
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                        w     <= '0;
                        En    <= 1'b0;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed table-driven bench for decoder_scan_ctrl across four parameter sets.
// Expectations follow the SCAN_BLANK_GAP_EN build when that macro is defined.
module tb_decoder_scan_ctrl;

    localparam int N = 4;
    localparam int PRE  [N] = '{4, 2, 1, 3};
    localparam int LAST [N] = '{15, 15, 0, 3};
`ifdef SCAN_BLANK_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic       hold;
        logic [6:0] exp;   // {w, En, Busy, Done}
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Stop  = 1'b0;
    logic       Mode  = 1'b0;
    logic       Hold  = 1'b0;
    logic [3:0] w_o    [N];
    logic       en_o   [N];
    logic       busy_o [N];
    logic       done_o [N];
    logic [1:0] st_o   [N];

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            decoder_scan_ctrl #(.PRESCALE(PRE[g]), .LAST_ADDR(LAST[g])) dut (
                .Clock     (Clock),
                .Reset     (Reset),
                .Start     (Start),
                .Stop      (Stop),
                .Mode      (Mode),
                .Hold      (Hold),
                .w         (w_o[g]),
                .En        (en_o[g]),
                .Busy      (busy_o[g]),
                .Done      (done_o[g]),
                .scan_state(st_o[g])
            );
        end
    endgenerate

    function automatic logic [6:0] obs(input int sel);
        return {w_o[sel], en_o[sel], busy_o[sel], done_o[sel]};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got w=%0d en=%b busy=%b done=%b, want w=%0d en=%b busy=%b done=%b",
                     name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic push(input logic st, input logic sp, input logic md, input logic hd,
                        input logic [3:0] ew, input logic een, input logic ebusy, input logic edone);
        vec_t v;
        v.start = st;
        v.stop  = sp;
        v.mode  = md;
        v.hold  = hd;
        v.exp   = {ew, een, ebusy, edone};
        tbl.push_back(v);
    endtask

    // Builds the expected cycle sequence of a run that starts from idle.
    task automatic gen(input int p, input int l, input logic mode, input logic keep_start,
                       input int hold_a, input int hold_d, input int hold_n,
                       input bit stop_end, input int sweeps);
        bit first;
        first = 1'b1;
        for (int s = 0; s < sweeps; s++) begin
            for (int a = 0; a <= l; a++) begin
                if (!first && GAP)
                    push(keep_start, 1'b0, !mode, 1'b0, 4'(a), 1'b0, 1'b1, (a == 0));
                for (int d = 0; d < p; d++) begin
                    push(first ? 1'b1 : keep_start, 1'b0, first ? mode : !mode, 1'b0,
                         4'(a), 1'b1, 1'b1, (!first && a == 0 && d == 0 && !GAP));
                    first = 1'b0;
                    if (s == 0 && a == hold_a && d == hold_d)
                        for (int n = 0; n < hold_n; n++)
                            push(keep_start, 1'b0, !mode, 1'b1, 4'(a), 1'b1, 1'b1, 1'b0);
                end
            end
        end
        if (mode == 1'b0) begin
            if (stop_end) push(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            else          push(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        end else begin
            push(keep_start, 1'b0, 1'b0, 1'b0, 4'd0, !GAP, 1'b1, 1'b1);
            push(keep_start, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_table(input int sel, input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            Start = tbl[i].start;
            Stop  = tbl[i].stop;
            Mode  = tbl[i].mode;
            Hold  = tbl[i].hold;
            @(posedge Clock);
            #2;
            check($sformatf("%s[%0d]", name, i), obs(sel), tbl[i].exp);
        end
        tbl.delete();
        Start = 1'b0;
        Stop  = 1'b0;
        Mode  = 1'b0;
        Hold  = 1'b0;
    endtask

    task automatic do_reset();
        Start = 1'b0;
        Stop  = 1'b0;
        Mode  = 1'b0;
        Hold  = 1'b0;
        Reset = 1'b1;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        @(posedge Clock);
        #2;
    endtask

    initial begin
        int k;

        // Reset state, observed before the first clock edge.
        #1 Reset = 1'b1;
        #2;
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset_out%0d", i), obs(i), 7'd0);
            check($sformatf("reset_state%0d", i), {5'd0, st_o[i]}, 7'd0);
        end
        do_reset();

        // Single sweep, PRESCALE=4, LAST_ADDR=15; Mode toggled while busy.
        gen(PRE[0], LAST[0], 1'b0, 1'b0, -1, 0, 0, 1'b0, 1);
        run_table(0, "single");

        // Hold for 5 cycles at w=6 with dwell=1.
        do_reset();
        gen(PRE[0], LAST[0], 1'b0, 1'b0, 6, 1, 5, 1'b0, 1);
        run_table(0, "hold");

        // Stop on the terminal event, then Start+Stop together in idle.
        do_reset();
        gen(PRE[0], LAST[0], 1'b0, 1'b0, -1, 0, 0, 1'b1, 1);
        push(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        run_table(0, "stop_tie");

        // Continuous, PRESCALE=2, Start held and Mode=0 while busy; Stop at a wrap.
        do_reset();
        gen(PRE[1], LAST[1], 1'b1, 1'b1, -1, 0, 0, 1'b1, 2);
        run_table(1, "cont");

        // LAST_ADDR=0 with PRESCALE=1: back-to-back Done in continuous mode.
        do_reset();
        gen(PRE[2], LAST[2], 1'b1, 1'b0, -1, 0, 0, 1'b1, 6);
        run_table(2, "p1_l0");

        // PRESCALE=3, LAST_ADDR=3 single sweep (gap pattern when enabled).
        do_reset();
        gen(PRE[3], LAST[3], 1'b0, 1'b0, -1, 0, 0, 1'b0, 1);
        run_table(3, "p3_l3");

        // Asynchronous reset mid-cycle at w=9.
        do_reset();
        Start = 1'b1;
        @(posedge Clock);
        #2;
        Start = 1'b0;
        k = 0;
        while (w_o[0] != 4'd9 && k < 200) begin
            @(posedge Clock);
            #2;
            k++;
        end
        check("reach_w9", obs(0), {4'd9, 1'b1, 1'b1, 1'b0});
        #1 Reset = 1'b1;
        #1;
        check("async_reset", obs(0), 7'd0);
        #1 Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #2;
            check($sformatf("post_reset_idle%0d", i), obs(0), 7'd0);
        end
        Start = 1'b1;
        @(posedge Clock);
        #2;
        Start = 1'b0;
        check("restart", obs(0), {4'd0, 1'b1, 1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
